// File: rtl/zuse_fp_mul_seq.sv
// zuse_fp_mul_seq -- sequential floating-point multiplier for the FPU datapath.
// Operands are sign / two's-complement exponent / mantissa with an explicit
// leading bit. Zero is encoded as e = most negative exponent, m = 0, s = 0.
// The mantissa product is built by shift-add, one multiplier bit per cycle.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start             one-cycle request, only honoured in IDLE
//   a_s/a_e/a_m       operand A sign / exponent / mantissa
//   b_s/b_e/b_m       operand B sign / exponent / mantissa
//   res_s/res_e/res_m registered result, updated only when done pulses
//   zero_flag         result is zero (operand zero or underflow)
//   overflow_flag     exponent overflow, result saturated
//   underflow_flag    exponent underflow, result forced to zero
//   idle              high while waiting for a request
//   done              one-cycle pulse in the cycle the result updates
module zuse_fp_mul_seq #(
  parameter int EXP_W = 7,
  parameter int MAN_W = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             a_s,
  input  logic [EXP_W-1:0] a_e,
  input  logic [MAN_W-1:0] a_m,
  input  logic             b_s,
  input  logic [EXP_W-1:0] b_e,
  input  logic [MAN_W-1:0] b_m,
  output logic             res_s,
  output logic [EXP_W-1:0] res_e,
  output logic [MAN_W-1:0] res_m,
  output logic             zero_flag,
  output logic             overflow_flag,
  output logic             underflow_flag,
  output logic             idle,
  output logic             done
);

  localparam int PW = 2 * MAN_W;
  localparam int CW = $clog2(MAN_W);
  localparam logic [EXP_W-1:0] ZERO_E = {1'b1, {(EXP_W-1){1'b0}}};
  localparam logic signed [EXP_W+1:0] EXP_MAX = (EXP_W+2)'(2**(EXP_W-1) - 1);
  localparam logic signed [EXP_W+1:0] EXP_MIN = -EXP_MAX;

  typedef enum logic [2:0] {IDLE, LOAD, MUL, NORM, DONE} state_t;

  state_t state, state_nx;

  logic             as_r, bs_r;
  logic [EXP_W-1:0] ae_r, be_r;
  logic [MAN_W-1:0] am_r, bm_r;
  logic             sign_r;
  logic [EXP_W:0]   exp_sum;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    cnt;

  logic                    op_zero;
  logic [PW-1:0]           partial;
  logic signed [EXP_W+1:0] norm_exp;
  logic [MAN_W-1:0]        norm_m;

  // An operand counts as zero if it carries the zero exponent or is not
  // normalized; either way the multiply is skipped.
  assign op_zero = (ae_r == ZERO_E) || !am_r[MAN_W-1] ||
                   (be_r == ZERO_E) || !bm_r[MAN_W-1];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: state_nx = op_zero ? DONE : MUL;
      MUL:  if (cnt == CW'(MAN_W-1)) state_nx = NORM;
      NORM: state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    idle = (state == IDLE);
    done = (state == DONE);
  end

  // Shifted multiplicand and the normalization of the finished product.
  // Both operands are normalized, so the product's top set bit is P[29] or P[28].
  always_comb begin
    partial  = PW'(am_r) << cnt;
    norm_exp = {exp_sum[EXP_W], exp_sum} + {{(EXP_W+1){1'b0}}, acc[PW-1]};
    norm_m   = acc[PW-1] ? acc[PW-1:MAN_W] : acc[PW-2:MAN_W-1];
  end

  // Datapath: operand capture, shift-add accumulation, result registers.
  // Result and flags are written on the edge that enters DONE, so they change
  // exactly in the done cycle and the old result stays visible while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      as_r <= 1'b0; ae_r <= '0; am_r <= '0;
      bs_r <= 1'b0; be_r <= '0; bm_r <= '0;
      sign_r <= 1'b0; exp_sum <= '0; acc <= '0; cnt <= '0;
      res_s <= 1'b0; res_e <= ZERO_E; res_m <= '0;
      zero_flag <= 1'b0; overflow_flag <= 1'b0; underflow_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            as_r <= a_s; ae_r <= a_e; am_r <= a_m;
            bs_r <= b_s; be_r <= b_e; bm_r <= b_m;
          end
        end
        LOAD: begin
          sign_r  <= as_r ^ bs_r;
          exp_sum <= {ae_r[EXP_W-1], ae_r} + {be_r[EXP_W-1], be_r};
          acc     <= '0;
          cnt     <= '0;
          if (op_zero) begin
            res_s <= 1'b0; res_e <= ZERO_E; res_m <= '0;
            zero_flag <= 1'b1; overflow_flag <= 1'b0; underflow_flag <= 1'b0;
          end
        end
        MUL: begin
          if (bm_r[cnt]) acc <= acc + partial;
          cnt <= cnt + 1'b1;
        end
        NORM: begin
          if (norm_exp > EXP_MAX) begin
            res_s <= sign_r; res_e <= {1'b0, {(EXP_W-1){1'b1}}}; res_m <= '1;
            zero_flag <= 1'b0; overflow_flag <= 1'b1; underflow_flag <= 1'b0;
          end else if (norm_exp < EXP_MIN) begin
            res_s <= 1'b0; res_e <= ZERO_E; res_m <= '0;
            zero_flag <= 1'b1; overflow_flag <= 1'b0; underflow_flag <= 1'b1;
          end else begin
            res_s <= sign_r; res_e <= norm_exp[EXP_W-1:0]; res_m <= norm_m;
            zero_flag <= 1'b0; overflow_flag <= 1'b0; underflow_flag <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/zuse_fp_mul_seq.md
Name: zuse_fp_mul_seq

Overview:
- Sequential floating-point multiplier that sits directly downstream of the UART command controller, in the floating-point unit datapath.
- Consumes the R1/R2 operand registers on a one-cycle start pulse and produces the RS result plus zero/overflow/underflow flags.
- Handshakes with the controller's WAIT state through idle/done.
- Mantissa product is built by shift-add, one multiplier bit per cycle.

Parameters:
- EXP_W, 7, exponent width; two's complement, range -64..63.
- MAN_W, 15, mantissa width; explicit leading bit at m[MAN_W-1].

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- a_s  in  1  operand A sign
- a_e  in  7  operand A exponent
- a_m  in  15  operand A mantissa
- b_s  in  1  operand B sign
- b_e  in  7  operand B exponent
- b_m  in  15  operand B mantissa
- res_s  out  1  result sign
- res_e  out  7  result exponent
- res_m  out  15  result mantissa
- zero_flag  out  1  result is zero (includes underflow)
- overflow_flag  out  1  exponent overflow
- underflow_flag  out  1  exponent underflow
- idle  out  1  high in IDLE state
- done  out  1  one-cycle pulse when results update

Interface (already decided): one clock; reset is synchronous and active-high (clk, reset).

Behaviour:
- Number format:
  - value = (-1)^s * (m / 2^14) * 2^e.
  - Normalized nonzero values have m[14]=1.
  - Zero is encoded as e=7'h40 (-64), m=0, s=0.
  - An operand with e=-64 or m[14]=0 is treated as zero.
- Reset: state=IDLE; res_s=0, res_e=7'h40, res_m=0; all flags 0; done=0; idle=1. Reset mid-operation aborts the operation immediately and applies these values.
- States: IDLE, LOAD, MUL, NORM, DONE.
  - IDLE: on start=1, latch all six operand inputs and go to LOAD. start is ignored in every other state; operand inputs may change after the start cycle.
  - LOAD:
    - sign = a_s ^ b_s.
    - exp_sum = sext8(a_e) + sext8(b_e).
    - acc = 0, cnt = 0.
    - If either operand is zero, go to DONE with zero result (s=0, e=-64, m=0, zero_flag=1); otherwise go to MUL.
  - MUL: 15 cycles. Each cycle: if multiplier bit[cnt] (LSB first) is 1, add multiplicand << cnt into the 30-bit acc; cnt++. Exit to NORM after cnt=14.
  - NORM:
    - If P[29]=1: m = P[29:15], exp = exp_sum + 1. Otherwise: m = P[28:14], exp = exp_sum.
    - Truncate; no rounding.
    - exp > 63: overflow_flag=1; e=7'h3F, m=15'h7FFF; sign kept.
    - exp < -63: underflow_flag=1, zero_flag=1; zero result encoding.
    - Otherwise: normal result, all flags 0.
  - DONE: registered result and flags update; done=1 for this cycle only; return to IDLE.
- Latency: counted from the edge that samples start.
  - Normal path: done high in cycle 18.
  - Zero-operand path: done high in cycle 2.
- Flag and result timing: flags and result change only in the DONE cycle and hold until the next DONE or reset. The previous result stays visible while busy.
- idle is combinational from state: low from the cycle after start through the DONE cycle, high again the cycle after done.
- Back-to-back: a start asserted in the cycle idle returns high is accepted.

Test Plan:
- 1.0 * 1.0: A=(0, 0, 0x4000), B=(0, 0, 0x4000), start -> done at cycle 18; res=(0, 0, 0x4000); flags 000.
- 1.5 * 1.5: A=B=(0, 0, 0x6000) -> res=(0, 1, 0x4800), i.e. 2.25; exercises the P[29] normalize path.
- 3.0 * -2.0: A=(0, 1, 0x6000), B=(1, 1, 0x4000) -> res=(1, 2, 0x6000), i.e. -6.0.
- Exponent limits:
  - e=40 with e=40 -> overflow_flag=1, res_e=0x3F, res_m=0x7FFF.
  - e=-40 with e=-40 -> underflow_flag=1, zero_flag=1, res=(0, 0x40, 0).
- Zero operand: A=(1, -64, 0), B=any -> done at cycle 2; res=(0, 0x40, 0), zero_flag=1. Also check that start pulses during a normal operation are ignored.
- Reset mid-operation: assert reset at cycle 8 of a multiply -> next cycle idle=1, done=0, res=(0, 0x40, 0), flags 0; a new start after reset completes correctly.
